// File: rtl/pc_stack_unit.sv
// Program-counter unit with sequencing modes, a hardware return-address stack
// and single-level interrupt entry/exit.
module pc_stack_unit #(
   parameter int ADDR_WIDTH   = 10,
   parameter int RESET_VECTOR = 256,
   parameter int IRQ_VECTOR   = 4,
   parameter int STACK_DEPTH  = 8
) (
   input  logic                         clock,
   input  logic                         resetCPU_n,
   input  logic [ADDR_WIDTH-1:0]        address,
   input  logic                         zero,
   input  logic                         negative,
   input  logic                         bzero,
   input  logic                         bnegative,
   input  logic                         jump,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         reti,
   input  logic                         HLT,
   input  logic                         irq_req,
   output logic [ADDR_WIDTH-1:0]        programCounter,
   output logic                         irq_ack,
   output logic                         in_isr,
   output logic [$clog2(STACK_DEPTH):0] stack_level,
   output logic                         stack_overflow,
   output logic                         stack_underflow
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(STACK_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RST_PC    = ADDR_WIDTH'(RESET_VECTOR);
   localparam logic [ADDR_WIDTH-1:0] IRQ_PC    = ADDR_WIDTH'(IRQ_VECTOR);

   // Sequential target when no stack operation or halt applies.
   function automatic logic [ADDR_WIDTH-1:0] seq_target(
      input logic [ADDR_WIDTH-1:0] pc_inc,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  jmp,
      input logic                  sel
   );
      logic [ADDR_WIDTH-1:0] tgt;
      if (jmp) begin
         tgt = addr;
      end else if (sel) begin
         tgt = pc_inc + addr;
      end else begin
         tgt = pc_inc;
      end
      return tgt;
   endfunction

   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] stack_mem_r [STACK_DEPTH];
   logic [LVL_W-1:0]      level_r;
   logic                  in_isr_r;
   logic                  irq_ack_r;
   logic                  ovf_r;
   logic                  unf_r;

   logic [ADDR_WIDTH-1:0] pc_inc_s;
   logic [ADDR_WIDTH-1:0] seq_pc_s;
   logic [ADDR_WIDTH-1:0] next_pc_s;
   logic [ADDR_WIDTH-1:0] push_data_s;
   logic [PTR_W-1:0]      wr_ptr_s;
   logic [PTR_W-1:0]      rd_ptr_s;
   logic                  select_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  irq_take_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  set_ovf_s;
   logic                  set_unf_s;
   logic                  clr_isr_s;

   assign pc_inc_s   = pc_r + ADDR_WIDTH'(1);
   assign select_s   = (bzero & zero) | (bnegative & negative);
   assign seq_pc_s   = seq_target(pc_inc_s, address, jump, select_s);
   assign full_s     = (level_r == FULL_LVL);
   assign empty_s    = (level_r == LVL_W'(0));
   assign wr_ptr_s   = level_r[PTR_W-1:0];
   assign rd_ptr_s   = wr_ptr_s - PTR_W'(1);
   // A blocked request is simply re-evaluated next cycle; nothing is latched.
   assign irq_take_s = irq_req & ~in_isr_r & ~call & ~ret & ~reti & ~full_s;

   // Priority resolution of the next PC and stack operation.
   always_comb begin
      next_pc_s   = pc_inc_s;
      push_data_s = pc_inc_s;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      set_ovf_s   = 1'b0;
      set_unf_s   = 1'b0;
      clr_isr_s   = 1'b0;
      if (irq_take_s) begin
         push_s      = 1'b1;
         push_data_s = HLT ? pc_inc_s : seq_pc_s;
         next_pc_s   = IRQ_PC;
      end else if (HLT) begin
         next_pc_s = pc_r;
      end else if (reti || ret) begin
         clr_isr_s = reti;
         if (!empty_s) begin
            pop_s     = 1'b1;
            next_pc_s = stack_mem_r[rd_ptr_s];
         end else begin
            set_unf_s = 1'b1;
         end
      end else if (call) begin
         if (!full_s) begin
            push_s    = 1'b1;
            next_pc_s = address;
         end else begin
            set_ovf_s = 1'b1;
         end
      end else begin
         next_pc_s = seq_pc_s;
      end
   end

   // Control state: PC, stack level, ISR flag, ack pulse and sticky errors.
   always_ff @(posedge clock or negedge resetCPU_n) begin
      if (!resetCPU_n) begin
         pc_r      <= RST_PC;
         level_r   <= LVL_W'(0);
         in_isr_r  <= 1'b0;
         irq_ack_r <= 1'b0;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
      end else begin
         pc_r      <= next_pc_s;
         irq_ack_r <= irq_take_s;
         ovf_r     <= ovf_r | set_ovf_s;
         unf_r     <= unf_r | set_unf_s;
         if (irq_take_s) begin
            in_isr_r <= 1'b1;
         end else if (clr_isr_s) begin
            in_isr_r <= 1'b0;
         end
         if (push_s) begin
            level_r <= level_r + LVL_W'(1);
         end else if (pop_s) begin
            level_r <= level_r - LVL_W'(1);
         end
      end
   end

   // Return-address storage; contents are meaningless after reset.
   always_ff @(posedge clock) begin
      if (resetCPU_n && push_s) begin
         stack_mem_r[wr_ptr_s] <= push_data_s;
      end
   end

   assign programCounter  = pc_r;
   assign irq_ack         = irq_ack_r;
   assign in_isr          = in_isr_r;
   assign stack_level     = level_r;
   assign stack_overflow  = ovf_r;
   assign stack_underflow = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: queue-based reference model, directed
// scenarios with literal expectations, then randomized strobes.
module tb_pc_stack_unit;

   localparam int AW    = 10;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          resetCPU_n;
   logic [AW-1:0] address;
   logic          zero, negative, bzero, bnegative, jump, call, ret, reti, HLT, irq_req;
   logic [AW-1:0] programCounter;
   logic          irq_ack, in_isr, stack_overflow, stack_underflow;
   logic [3:0]    stack_level;

   always #5 clock = ~clock;

   pc_stack_unit #(
      .ADDR_WIDTH(AW), .RESET_VECTOR(256), .IRQ_VECTOR(4), .STACK_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .resetCPU_n(resetCPU_n), .address(address), .zero(zero),
      .negative(negative), .bzero(bzero), .bnegative(bnegative), .jump(jump),
      .call(call), .ret(ret), .reti(reti), .HLT(HLT), .irq_req(irq_req),
      .programCounter(programCounter), .irq_ack(irq_ack), .in_isr(in_isr),
      .stack_level(stack_level), .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stk[$];
   bit m_isr, m_ack, m_ovf, m_unf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = AW'(256);
      m_stk.delete();
      m_isr = 1'b0; m_ack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   // One clock edge of architectural behaviour, using the inputs present at the edge.
   task automatic model_update();
      logic [AW-1:0] inc, seq;
      bit sel, take;
      inc  = m_pc + AW'(1);
      sel  = (bzero && zero) || (bnegative && negative);
      seq  = jump ? address : (sel ? AW'(inc + address) : inc);
      take = irq_req && !m_isr && !call && !ret && !reti && (m_stk.size() < DEPTH);
      m_ack = take;
      if (take) begin
         m_stk.push_back(HLT ? inc : seq);
         m_pc  = AW'(4);
         m_isr = 1'b1;
      end else if (HLT) begin
         m_pc = m_pc;
      end else if (reti || ret) begin
         if (reti) m_isr = 1'b0;
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else begin m_pc = inc; m_unf = 1'b1; end
      end else if (call) begin
         if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); m_pc = address; end
         else begin m_pc = inc; m_ovf = 1'b1; end
      end else begin
         m_pc = seq;
      end
   endtask

   always @(negedge clock) begin
      if (check_en) begin
         chk("pc", 32'(programCounter), 32'(m_pc));
         chk("irq_ack", 32'(irq_ack), 32'(m_ack));
         chk("in_isr", 32'(in_isr), 32'(m_isr));
         chk("stack_level", 32'(stack_level), 32'(m_stk.size()));
         chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
         chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
      end
   end

   task automatic clear_in();
      address = '0; zero = 1'b0; negative = 1'b0; bzero = 1'b0; bnegative = 1'b0;
      jump = 1'b0; call = 1'b0; ret = 1'b0; reti = 1'b0; HLT = 1'b0; irq_req = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_update();
      #1;
   endtask

   // Asserts reset between edges and checks that it acts before any clock.
   task automatic do_reset();
      resetCPU_n = 1'b0;
      #1;
      chk("async_reset_pc", 32'(programCounter), 32'd256);
      chk("async_reset_level", 32'(stack_level), 32'd0);
      model_reset();
      @(negedge clock);
      #1;
      resetCPU_n = 1'b1;
   endtask

   task automatic jump_to(input logic [AW-1:0] a);
      clear_in(); jump = 1'b1; address = a; cycle(); clear_in();
   endtask

   initial begin
      resetCPU_n = 1'b0;
      clear_in();
      model_reset();
      check_en = 1'b1;
      #12;
      resetCPU_n = 1'b1;
      chk("reset_pc", 32'(programCounter), 32'd256);
      chk("reset_level", 32'(stack_level), 32'd0);
      cycle(); chk("inc_257", 32'(programCounter), 32'd257);
      cycle(); chk("inc_258", 32'(programCounter), 32'd258);

      jump_to(AW'(300));
      bzero = 1'b1; zero = 1'b1; address = AW'(10'h3F6); cycle();
      chk("branch_taken", 32'(programCounter), 32'd291);
      jump_to(AW'(300));
      bzero = 1'b1; zero = 1'b0; address = AW'(10'h3F6); cycle();
      chk("branch_not_taken", 32'(programCounter), 32'd301);
      jump_to(AW'(1023));
      cycle(); chk("pc_wrap", 32'(programCounter), 32'd0);

      jump_to(AW'(256));
      call = 1'b1; address = AW'(500); cycle(); clear_in();
      chk("call_pc", 32'(programCounter), 32'd500);
      chk("call_level", 32'(stack_level), 32'd1);
      ret = 1'b1; cycle(); clear_in();
      chk("ret_pc", 32'(programCounter), 32'd257);
      chk("ret_level", 32'(stack_level), 32'd0);

      do_reset();
      jump_to(AW'(50));
      for (int i = 0; i < 8; i++) begin
         clear_in(); call = 1'b1; address = AW'(100 + 10 * i); cycle();
      end
      clear_in(); call = 1'b1; address = AW'(999); cycle(); clear_in();
      chk("ovf_pc", 32'(programCounter), 32'd171);
      chk("ovf_level", 32'(stack_level), 32'd8);
      chk("ovf_flag", 32'(stack_overflow), 32'd1);
      for (int i = 0; i < 8; i++) begin
         clear_in(); ret = 1'b1; cycle();
      end
      chk("ret8_pc", 32'(programCounter), 32'd51);
      ret = 1'b1; cycle(); clear_in();
      chk("unf_pc", 32'(programCounter), 32'd52);
      chk("unf_flag", 32'(stack_underflow), 32'd1);
      chk("unf_level", 32'(stack_level), 32'd0);

      do_reset();
      jump_to(AW'(260));
      HLT = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(); chk("halt_hold", 32'(programCounter), 32'd260);
      end
      irq_req = 1'b1; cycle(); clear_in();
      chk("irq_halt_pc", 32'(programCounter), 32'd4);
      chk("irq_halt_ack", 32'(irq_ack), 32'd1);
      chk("irq_halt_isr", 32'(in_isr), 32'd1);
      cycle(); chk("ack_pulse_end", 32'(irq_ack), 32'd0);
      reti = 1'b1; cycle(); clear_in();
      chk("reti_pc", 32'(programCounter), 32'd261);
      chk("reti_isr", 32'(in_isr), 32'd0);

      irq_req = 1'b1; cycle();
      chk("irq_entry_ack", 32'(irq_ack), 32'd1);
      cycle(); chk("irq_held_no_ack1", 32'(irq_ack), 32'd0);
      cycle(); chk("irq_held_no_ack2", 32'(irq_ack), 32'd0);
      chk("irq_held_pc", 32'(programCounter), 32'd6);
      clear_in(); reti = 1'b1; cycle(); clear_in();
      chk("reti_seq_pc", 32'(programCounter), 32'd262);
      call = 1'b1; irq_req = 1'b1; address = AW'(600); cycle();
      chk("call_beats_irq_pc", 32'(programCounter), 32'd600);
      chk("call_beats_irq_ack", 32'(irq_ack), 32'd0);
      call = 1'b0; cycle(); clear_in();
      chk("irq_after_call_pc", 32'(programCounter), 32'd4);
      chk("irq_after_call_level", 32'(stack_level), 32'd2);
      reti = 1'b1; cycle(); clear_in();
      chk("reti_after_call_pc", 32'(programCounter), 32'd601);

      call = 1'b1; address = AW'(700); cycle();
      address = AW'(710); cycle(); clear_in();
      chk("pre_reset_level", 32'(stack_level), 32'd3);
      do_reset();

      for (int k = 0; k < 3000; k++) begin
         address   = AW'($urandom);
         zero      = 1'($urandom_range(0, 1));
         negative  = 1'($urandom_range(0, 1));
         bzero     = ($urandom_range(0, 3) == 0);
         bnegative = ($urandom_range(0, 3) == 0);
         jump      = ($urandom_range(0, 9) == 0);
         call      = ($urandom_range(0, 5) == 0);
         ret       = ($urandom_range(0, 7) == 0);
         reti      = ($urandom_range(0, 11) == 0);
         HLT       = ($urandom_range(0, 9) == 0);
         irq_req   = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 399) == 0) do_reset();
         else cycle();
      end

      clear_in();
      cycle();
      @(negedge clock);
      #1;
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
